// File: rtl/dht11_drv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dht11_drv                                                  |
// | Description : One-wire DHT11 master. Periodically starts a read, times   |
// |               the 40-bit response, validates it and publishes the        |
// |               temperature/humidity bytes as BCD digits for the UART      |
// |               reporting stage.                                           |
// | Config      : DHT11_CRC_EN - when defined, the checksum byte is checked  |
// |               and a mismatch sets err; otherwise every complete frame    |
// |               is accepted.                                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dht11_drv #(
  parameter int CLK_FRE    = 50,
  parameter int SAMPLE_MS  = 1000,
  parameter int START_MS   = 18,
  parameter int TMO_US     = 200,
  parameter int BIT_THR_US = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  inout  wire         dht11_io,
  output logic [23:0] dht11_data,
  output logic        data_valid,
  output logic        err
);

  // Prescaler width; a 1-cycle tick still needs a 1-bit register.
  localparam int               c_DIV_W    = (CLK_FRE > 1) ? $clog2(CLK_FRE) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(CLK_FRE - 1);
  // Last microsecond index of the IDLE and START intervals.
  localparam logic [31:0]      c_IDLE_US  = 32'(SAMPLE_MS * 1000 - 1);
  localparam logic [31:0]      c_START_US = 32'(START_MS * 1000 - 1);
  localparam logic [31:0]      c_TMO_US   = 32'(TMO_US);
  localparam logic [31:0]      c_THR_US   = 32'(BIT_THR_US);
  localparam logic [5:0]       c_LAST_BIT = 6'd39;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_WAIT_R = 3'd2,
    S_RESP_L = 3'd3,
    S_RESP_H = 3'd4,
    S_BIT_L  = 3'd5,
    S_BIT_H  = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_sync;
  logic                r_prev;
  logic                w_rise;
  logic                w_fall;
  logic [c_DIV_W-1:0]  r_div;
  logic                w_tick;
  logic [31:0]         r_us;
  logic                w_state_chg;
  logic                w_tmo_hit;
  logic [5:0]          r_bit_cnt;
  logic [39:0]         r_shift;
  logic                w_bit;
  logic                w_shift_en;
  logic                w_frame_start;
  logic                w_timeout;
  logic                w_frame_done;
  logic                w_frame_good;
  logic                r_drive_low;
  logic                w_unused_bits;

  // Convert one byte to two BCD digits; anything above 99 saturates to 99.
  function automatic logic [7:0] f_bcd(input logic [7:0] b);
    logic [3:0] tens;
    logic [3:0] units;
    if (b > 8'd99) begin
      f_bcd = 8'h99;
    end else begin
      tens  = 4'(b / 8'd10);
      units = 4'(b - ({4'd0, tens} * 8'd10));
      f_bcd = {tens, units};
    end
  endfunction

  // Open-drain bus: only ever pull low, otherwise release to the pull-up.
  assign dht11_io = r_drive_low ? 1'b0 : 1'bz;

  // Two-flop synchronizer plus a history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], dht11_io};
      r_prev <= r_sync[1];
    end
  end

  assign w_rise = r_sync[1] & ~r_prev;
  assign w_fall = ~r_sync[1] & r_prev;

  // Microsecond timebase, restarted whenever the FSM changes state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_us  <= '0;
    end else if (w_state_chg) begin
      r_div <= '0;
      r_us  <= '0;
    end else if (w_tick) begin
      r_div <= '0;
      r_us  <= r_us + 32'd1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_tick      = (r_div == c_DIV_MAX);
  assign w_state_chg = (w_next != r_state);
  assign w_tmo_hit   = (r_us > c_TMO_US);
  // High-phase length in BIT_H is the state-local microsecond count.
  assign w_bit       = (r_us > c_THR_US);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    w_next        = r_state;
    w_shift_en    = 1'b0;
    w_frame_start = 1'b0;
    w_timeout     = 1'b0;
    w_frame_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick && (r_us == c_IDLE_US)) w_next = S_START;
      end
      S_START: begin
        if (w_tick && (r_us == c_START_US)) w_next = S_WAIT_R;
      end
      S_WAIT_R: begin
        if (w_fall) begin
          w_next = S_RESP_L;
        end else if (w_tmo_hit) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_RESP_L: begin
        if (w_rise) begin
          w_next = S_RESP_H;
        end else if (w_tmo_hit) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_RESP_H: begin
        if (w_fall) begin
          w_frame_start = 1'b1;
          w_next        = S_BIT_L;
        end else if (w_tmo_hit) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_BIT_L: begin
        if (w_rise) begin
          w_next = S_BIT_H;
        end else if (w_tmo_hit) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_BIT_H: begin
        if (w_fall) begin
          w_shift_en = 1'b1;
          w_next     = (r_bit_cnt == c_LAST_BIT) ? S_DONE : S_BIT_L;
        end else if (w_tmo_hit) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_DONE: begin
        w_frame_done = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Bit counter and MSB-first shift register; a new frame clears both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_frame_start) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_shift_en) begin
      r_bit_cnt <= r_bit_cnt + 6'd1;
      r_shift   <= {r_shift[38:0], w_bit};
    end
  end

`ifdef DHT11_CRC_EN
  logic [7:0] w_sum;
  assign w_sum         = r_shift[39:32] + r_shift[31:24] + r_shift[23:16] + r_shift[15:8];
  assign w_frame_good  = (w_sum == r_shift[7:0]);
  assign w_unused_bits = 1'b0;
`else
  // Checksum and H_DEC are received but not consumed in this build.
  assign w_frame_good  = 1'b1;
  assign w_unused_bits = ^{r_shift[31:24], r_shift[7:0]};
`endif

  // Result registers: publish good frames, flag timeouts and bad checksums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dht11_data <= '0;
      data_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (w_timeout) begin
        err <= 1'b1;
      end else if (w_frame_done) begin
        if (w_frame_good) begin
          dht11_data <= {f_bcd(r_shift[23:16]), f_bcd(r_shift[15:8]), f_bcd(r_shift[39:32])};
          data_valid <= 1'b1;
          err        <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

  // Host start pulse: hold the line low for the whole START state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_drive_low <= 1'b0;
    else        r_drive_low <= (w_next == S_START);
  end

endmodule
`default_nettype wire

// File: tb/tb_dht11_drv.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dht11_drv                                               |
// | Description : Directed bench for dht11_drv with a behavioural sensor     |
// |               and a pull-up on the one-wire bus.                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_dht11_drv;

  localparam int CLK_FRE    = 2;
  localparam int SAMPLE_MS  = 1;
  localparam int START_MS   = 1;
  localparam int TMO_US     = 200;
  localparam int BIT_THR_US = 40;
  localparam int CLK_NS     = 1000 / CLK_FRE;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  wire         dht11_io;
  logic [23:0] dht11_data;
  logic        data_valid;
  logic        err;
  logic        sens_low = 1'b0;

  int  n_checks  = 0;
  int  n_pass    = 0;
  int  dv_count  = 0;
  int  dv_double = 0;
  logic dv_prev  = 1'b0;
  time host_low_ns;

  pullup (dht11_io);
  assign dht11_io = sens_low ? 1'b0 : 1'bz;

  always #(CLK_NS / 2) clk = ~clk;

  dht11_drv #(
    .CLK_FRE    (CLK_FRE),
    .SAMPLE_MS  (SAMPLE_MS),
    .START_MS   (START_MS),
    .TMO_US     (TMO_US),
    .BIT_THR_US (BIT_THR_US)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dht11_io   (dht11_io),
    .dht11_data (dht11_data),
    .data_valid (data_valid),
    .err        (err)
  );

  // Count data_valid pulses and any back-to-back assertion.
  always @(negedge clk) begin
    if (data_valid) dv_count++;
    if (data_valid && dv_prev) dv_double++;
    dv_prev = data_valid;
  end

  // Poll the bus once per cycle, just after the active edge.
  task automatic wait_bus(input logic lvl, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (dht11_io === lvl) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // Sensor: answer one host start with the given 40-bit frame.
  // abort_bit >= 0 stops (bus released) at the start of that bit's high phase.
  task automatic sensor_frame(input logic [39:0] frame, input int abort_bit);
    bit  ok;
    time t0;
    wait_bus(1'b0, 8000, ok);
    n_checks++;
    if (!ok) $display("FAIL host_start: bus low not seen, got %b required 0", dht11_io);
    else n_pass++;
    t0 = $time;
    wait_bus(1'b1, 8000, ok);
    n_checks++;
    if (!ok) $display("FAIL host_release: bus not released, got %b required 1", dht11_io);
    else n_pass++;
    host_low_ns = $time - t0;
    #99;
    #20000 sens_low = 1'b1;
    #80000 sens_low = 1'b0;
    #80000;
    for (int b = 39; b >= 0; b--) begin
      sens_low = 1'b1;
      #20000 sens_low = 1'b0;
      if ((39 - b) == abort_bit) return;
      if (frame[b]) #60000;
      else          #20000;
    end
    sens_low = 1'b1;
    #20000 sens_low = 1'b0;
    #1000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (dht11_data !== 24'h0) $display("FAIL reset_data: got %h required %h", dht11_data, 24'h0);
    else n_pass++;
    n_checks++;
    if (data_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", data_valid);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL reset_err: got %b required 0", err);
    else n_pass++;
    n_checks++;
    if (dht11_io !== 1'b1) $display("FAIL reset_bus: got %b required 1", dht11_io);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_good_frame();
    int dv0;
    dv0 = dv_count;
    sensor_frame({8'd55, 8'd0, 8'd26, 8'd5, 8'd86}, -1);
    n_checks++;
    if (host_low_ns < 1000000 - CLK_NS || host_low_ns > 1000000 + CLK_NS)
      $display("FAIL start_pulse_ns: got %0t required 1000000", host_low_ns);
    else n_pass++;
    n_checks++;
    if (dht11_data !== 24'h260555) $display("FAIL good_data: got %h required %h", dht11_data, 24'h260555);
    else n_pass++;
    n_checks++;
    if (dv_count - dv0 !== 1) $display("FAIL good_valid_pulses: got %0d required 1", dv_count - dv0);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL good_err: got %b required 0", err);
    else n_pass++;
  endtask

  task automatic test_timeout();
    bit  ok;
    time t_rel;
    time t_err;
    int  cyc;
    int  dv0;
    dv0 = dv_count;
    wait_bus(1'b0, 8000, ok);
    wait_bus(1'b1, 8000, ok);
    t_rel = $time;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (err === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    t_err = $time;
    n_checks++;
    if (err !== 1'b1) $display("FAIL tmo_err: got %b required 1", err);
    else n_pass++;
    cyc = int'((t_err - t_rel) / CLK_NS);
    n_checks++;
    if (cyc < (TMO_US + 1) * CLK_FRE || cyc > (TMO_US + 1) * CLK_FRE + 2)
      $display("FAIL tmo_cycles: got %0d required %0d", cyc, (TMO_US + 1) * CLK_FRE + 1);
    else n_pass++;
    n_checks++;
    if (dht11_data !== 24'h260555) $display("FAIL tmo_data: got %h required %h", dht11_data, 24'h260555);
    else n_pass++;
    n_checks++;
    if (dv_count - dv0 !== 0) $display("FAIL tmo_valid_pulses: got %0d required 0", dv_count - dv0);
    else n_pass++;
    wait_bus(1'b0, 8000, ok);
    cyc = int'(($time - t_err) / CLK_NS);
    n_checks++;
    if (cyc < SAMPLE_MS * 1000 * CLK_FRE - 1 || cyc > SAMPLE_MS * 1000 * CLK_FRE + 1)
      $display("FAIL tmo_restart_cycles: got %0d required %0d", cyc, SAMPLE_MS * 1000 * CLK_FRE);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int dv0;
    dv0 = dv_count;
    sensor_frame({8'd120, 8'd0, 8'd30, 8'd0, 8'd150}, -1);
    n_checks++;
    if (dht11_data !== 24'h300099) $display("FAIL sat_data: got %h required %h", dht11_data, 24'h300099);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL sat_err: got %b required 0", err);
    else n_pass++;
    n_checks++;
    if (dv_count - dv0 !== 1) $display("FAIL sat_valid_pulses: got %0d required 1", dv_count - dv0);
    else n_pass++;
  endtask

  task automatic test_bad_checksum();
    int          dv0;
    logic [23:0] exp_data;
    logic        exp_err;
    int          exp_dv;
`ifdef DHT11_CRC_EN
    exp_data = 24'h300099;
    exp_err  = 1'b1;
    exp_dv   = 0;
`else
    exp_data = 24'h260555;
    exp_err  = 1'b0;
    exp_dv   = 1;
`endif
    dv0 = dv_count;
    sensor_frame({8'd55, 8'd0, 8'd26, 8'd5, 8'd87}, -1);
    n_checks++;
    if (dht11_data !== exp_data) $display("FAIL badcs_data: got %h required %h", dht11_data, exp_data);
    else n_pass++;
    n_checks++;
    if (err !== exp_err) $display("FAIL badcs_err: got %b required %b", err, exp_err);
    else n_pass++;
    n_checks++;
    if (dv_count - dv0 !== exp_dv) $display("FAIL badcs_valid_pulses: got %0d required %0d", dv_count - dv0, exp_dv);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int dv0;
    dv0 = dv_count;
    sensor_frame({8'd70, 8'd0, 8'd18, 8'd9, 8'd97}, -1);
    n_checks++;
    if (dht11_data !== 24'h180970) $display("FAIL b2b_first_data: got %h required %h", dht11_data, 24'h180970);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL b2b_first_err: got %b required 0", err);
    else n_pass++;
    n_checks++;
    if (dv_count - dv0 !== 1) $display("FAIL b2b_first_pulses: got %0d required 1", dv_count - dv0);
    else n_pass++;
    dv0 = dv_count;
    sensor_frame({8'd40, 8'd0, 8'd22, 8'd0, 8'd62}, -1);
    n_checks++;
    if (dht11_data !== 24'h220040) $display("FAIL b2b_second_data: got %h required %h", dht11_data, 24'h220040);
    else n_pass++;
    n_checks++;
    if (dv_count - dv0 !== 1) $display("FAIL b2b_second_pulses: got %0d required 1", dv_count - dv0);
    else n_pass++;
    n_checks++;
    if (dv_double !== 0) $display("FAIL valid_consecutive: got %0d required 0", dv_double);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int dv0;
    // Reset while bit 20 is in flight.
    sensor_frame({8'd11, 8'd0, 8'd22, 8'd3, 8'd36}, 20);
    #5000 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dht11_data !== 24'h0) $display("FAIL midrst_data: got %h required %h", dht11_data, 24'h0);
    else n_pass++;
    n_checks++;
    if (dht11_io !== 1'b1) $display("FAIL midrst_bus: got %b required 1", dht11_io);
    else n_pass++;
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    // Reset while the host is driving its start pulse.
    wait_bus(1'b0, 8000, ok);
    repeat (200) @(posedge clk);
    #137 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dht11_io !== 1'b1) $display("FAIL startrst_bus: got %b required 1", dht11_io);
    else n_pass++;
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    // Clean read afterwards, exercising the 99/100 saturation boundary.
    dv0 = dv_count;
    sensor_frame({8'd99, 8'd0, 8'd100, 8'd0, 8'd199}, -1);
    n_checks++;
    if (dht11_data !== 24'h990099) $display("FAIL postrst_data: got %h required %h", dht11_data, 24'h990099);
    else n_pass++;
    n_checks++;
    if (dv_count - dv0 !== 1) $display("FAIL postrst_pulses: got %0d required 1", dv_count - dv0);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL postrst_err: got %b required 0", err);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_timeout();
    test_saturation();
    test_bad_checksum();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case anything above stops making progress.
  initial begin
    #100_000_000;
    $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
